// File: rtl/axi_wr_resp_ram.sv
// axi_wr_resp_ram: AXI3 write-channel responder backed by an on-chip word RAM.
// One burst is accepted at a time. Byte strobes are applied to the RAM and one
// B response is returned per burst. A registered debug read port exposes RAM
// contents. Defining AXI_WR_BP_EN gates wready with a 16-bit LFSR so that the
// initiator sees pseudo-random backpressure.

module axi_wr_resp_ram #(
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_rdata
);

  localparam int         WIN_LSB     = ADDR_W + 2;
  localparam int         DEPTH       = 1 << ADDR_W;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic        w_awreadyNext;
  logic        w_wreadyNext;
  logic        w_bvalidNext;

  logic [3:0]  r_id;
  logic [31:0] r_addr;
  logic [3:0]  r_len;
  logic [1:0]  r_burst;
  logic [1:0]  r_resp;
  logic        r_awErr;
  logic [3:0]  r_cnt;
  logic [3:0]  r_bid;
  logic [1:0]  r_bresp;
  logic [31:0] r_dbgRdata;

  logic [31:0] r_mem [0:DEPTH-1];

  logic        w_wready;
  logic        w_awHs;
  logic        w_beat;
  logic        w_lastByCnt;
  logic        w_term;
  logic        w_awSlvErr;
  logic        w_awInWin;
  logic [1:0]  w_awResp;
  logic        w_beatInWin;
  logic        w_beatSlv;
  logic [1:0]  w_respAcc;
  logic        w_wrEn;
  logic [ADDR_W-1:0] w_wrIdx;
  logic [31:0] w_addrInc;
  logic [31:0] w_wrapMask;
  logic [31:0] w_addrNext;
  logic        w_unused;

  // Protection/cache/lock attributes carry no meaning for a plain RAM sink.
  assign w_unused = ^{awlock, awcache, awprot};

  assign awready   = r_awready;
  assign wready    = w_wready;
  assign bvalid    = r_bvalid;
  assign bid       = r_bid;
  assign bresp     = r_bresp;
  assign dbg_rdata = r_dbgRdata;

`ifdef AXI_WR_BP_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR (taps 16,14,13,11) that steps only while a burst is in its data phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lfsr <= 16'hACE1;
    end else if (r_state == ST_DATA) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_wready = r_wready & r_lfsr[0];
`else
  assign w_wready = r_wready;
`endif

  // Handshake qualifiers; the ready registers are only ever high in their own state.
  assign w_awHs      = awvalid & r_awready;
  assign w_beat      = wvalid & w_wready;
  assign w_lastByCnt = (r_cnt == r_len);
  assign w_term      = wlast | w_lastByCnt;

  // Error classification of the incoming AW request.
  assign w_awSlvErr = (awsize != 3'b010) || (awlen[7:4] != 4'd0) ||
                      ((awburst == BURST_WRAP) &&
                       !((awlen[3:0] == 4'd1) || (awlen[3:0] == 4'd3) ||
                         (awlen[3:0] == 4'd7) || (awlen[3:0] == 4'd15)));
  assign w_awInWin  = (awaddr[31:WIN_LSB] == BASE[31:WIN_LSB]);
  assign w_awResp   = w_awSlvErr ? RESP_SLVERR : (!w_awInWin ? RESP_DECERR : RESP_OKAY);

  // Per-beat checks: window membership of the current beat, ID match and wlast consistency.
  assign w_beatInWin = (r_addr[31:WIN_LSB] == BASE[31:WIN_LSB]);
  assign w_beatSlv   = (wid != r_id) || (wlast != w_lastByCnt);
  assign w_respAcc   = ((r_resp == RESP_SLVERR) || w_beatSlv) ? RESP_SLVERR :
                       ((r_resp == RESP_DECERR) || !w_beatInWin) ? RESP_DECERR : RESP_OKAY;

  // Beats only reach the RAM when the AW request was clean and the beat lands in the window.
  assign w_wrEn  = w_beat & ~r_awErr & w_beatInWin;
  assign w_wrIdx = r_addr[ADDR_W+1:2];

  // A legal WRAP length is 2^k-1 beats, so {len,2'b11} is exactly the byte-offset mask of the wrap block.
  assign w_addrInc  = r_addr + 32'd4;
  assign w_wrapMask = {26'd0, r_len, 2'b11};

  // Next beat address: FIXED holds, WRAP stays inside its aligned block, anything else increments.
  always_comb begin
    w_addrNext = w_addrInc;
    case (r_burst)
      BURST_FIXED: w_addrNext = r_addr;
      BURST_WRAP:  w_addrNext = (r_addr & ~w_wrapMask) | (w_addrInc & w_wrapMask);
      default:     w_addrNext = w_addrInc;
    endcase
  end

  // Burst sequencing IDLE -> DATA -> RESP and the registered handshake outputs for the next cycle.
  always_comb begin
    w_stateNext   = r_state;
    w_awreadyNext = 1'b0;
    w_wreadyNext  = 1'b0;
    w_bvalidNext  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_awHs) begin
          w_stateNext  = ST_DATA;
          w_wreadyNext = 1'b1;
        end else begin
          w_awreadyNext = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_beat && w_term) begin
          w_stateNext  = ST_RESP;
          w_bvalidNext = 1'b1;
        end else begin
          w_wreadyNext = 1'b1;
        end
      end
      ST_RESP: begin
        if (bready && r_bvalid) begin
          w_stateNext   = ST_IDLE;
          w_awreadyNext = 1'b1;
        end else begin
          w_bvalidNext = 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // State and handshake registers; reset aborts any burst in flight without a response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_awready <= w_awreadyNext;
      r_wready  <= w_wreadyNext;
      r_bvalid  <= w_bvalidNext;
    end
  end

  // Burst context: latched on AW, advanced per beat, and folded into the B response on the last beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_id    <= 4'd0;
      r_addr  <= 32'd0;
      r_len   <= 4'd0;
      r_burst <= 2'b00;
      r_resp  <= RESP_OKAY;
      r_awErr <= 1'b0;
      r_cnt   <= 4'd0;
      r_bid   <= 4'd0;
      r_bresp <= RESP_OKAY;
    end else if (w_awHs) begin
      r_id    <= awid;
      r_addr  <= awaddr;
      r_len   <= awlen[3:0];
      r_burst <= awburst;
      r_resp  <= w_awResp;
      r_awErr <= (w_awResp != RESP_OKAY);
      r_cnt   <= 4'd0;
    end else if (w_beat) begin
      r_addr <= w_addrNext;
      r_cnt  <= r_cnt + 4'd1;
      r_resp <= w_respAcc;
      if (w_term) begin
        r_bid   <= r_id;
        r_bresp <= w_respAcc;
      end
    end
  end

  // Byte-strobed RAM write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          r_mem[w_wrIdx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered debug read; a same-cycle write is not forwarded, so old data is returned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dbgRdata <= 32'd0;
    end else begin
      r_dbgRdata <= r_mem[dbg_addr];
    end
  end

endmodule

// File: tb/tb_axi_wr_resp_ram.sv
// tb_axi_wr_resp_ram: directed plus randomized bursts against a behavioural RAM/response model.

module tb_axi_wr_resp_ram;

  localparam int          ADDR_W    = 10;
  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam longint      WIN_BYTES = 4 * DEPTH;
  localparam int          TIMEOUT   = 100;

  logic              clk;
  logic              resetn;
  logic [3:0]        awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [3:0]        wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] dbgAddr;
  logic [31:0]       dbgRdata;

  int vecCount = 0;
  int errCount = 0;

  logic [31:0] modelMem [DEPTH];
  logic [31:0] beatData [16];
  logic [3:0]  beatStrb [16];
  logic [3:0]  beatWid  [16];
  logic        beatLast [16];
  int          touched  [$];

  axi_wr_resp_ram #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .awid      (awid),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awlock    (awlock),
    .awcache   (awcache),
    .awprot    (awprot),
    .awvalid   (awvalid),
    .awready   (awready),
    .wid       (wid),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bid       (bid),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .dbg_addr  (dbgAddr),
    .dbg_rdata (dbgRdata)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic inWindow(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua >= longint'(BASE)) && (ua < longint'(BASE) + WIN_BYTES);
  endfunction

  // Byte address of beat k computed arithmetically from the burst rules.
  function automatic logic [31:0] beatAddr(input logic [31:0] start, input logic [1:0] burst,
                                           input int len4, input int k);
    longint s, blk, base;
    s = longint'(start);
    if (burst == 2'b00) return start;
    if (burst == 2'b10) begin
      blk  = longint'((len4 + 1) * 4);
      base = s - (s % blk);
      return 32'(base + ((s - base + longint'(4 * k)) % blk));
    end
    return 32'(s + longint'(4 * k));
  endfunction

  function automatic int wordIdx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[ADDR_W+1:2]);
  endfunction

  task automatic setBeats(input logic [3:0] id, input int lastAt);
    for (int k = 0; k < 16; k++) begin
      beatData[k] = $urandom;
      beatStrb[k] = 4'hF;
      beatWid[k]  = id;
      beatLast[k] = (k == lastAt);
    end
  endtask

  // Reference model: expected response, RAM updates and the in-window words to read back.
  task automatic modelBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len8,
                            input logic [2:0] size, input logic [1:0] burst,
                            output logic [1:0] expResp, output int nb);
    int          len4;
    logic        slv, dec, awErr;
    logic [31:0] a;
    int          idx;
    len4  = int'(len8[3:0]);
    slv   = (size != 3'b010) || (len8[7:4] != 4'd0) ||
            (burst == 2'b10 && !(len4 == 1 || len4 == 3 || len4 == 7 || len4 == 15));
    dec   = !inWindow(addr);
    awErr = slv || dec;
    nb    = 0;
    for (int k = 0; k < 16; k++) begin
      if (beatLast[k] || k == len4) begin
        nb = k + 1;
        break;
      end
    end
    for (int k = 0; k < nb; k++) begin
      a = beatAddr(addr, burst, len4, k);
      if (beatWid[k] != id) slv = 1'b1;
      if (!inWindow(a)) begin
        dec = 1'b1;
      end else begin
        idx = wordIdx(a);
        touched.push_back(idx);
        if (!awErr) begin
          for (int b = 0; b < 4; b++) begin
            if (beatStrb[k][b]) modelMem[idx][8*b +: 8] = beatData[k][8*b +: 8];
          end
        end
      end
    end
    if (beatLast[nb-1] != ((nb - 1) == len4)) slv = 1'b1;
    expResp = slv ? 2'b10 : (dec ? 2'b11 : 2'b00);
  endtask

  task automatic sendAw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len8,
                        input logic [2:0] size, input logic [1:0] burst);
    int n;
    awid    = id;
    awaddr  = addr;
    awlen   = len8;
    awsize  = size;
    awburst = burst;
    awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    if (awready !== 1'b1) checkOutput("aw_timeout", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    checkOutput("aw_drop", 32'(awready), 32'd0);
`ifndef AXI_WR_BP_EN
    checkOutput("wready_lat", 32'(wready), 32'd1);
`endif
  endtask

  task automatic sendBeat(input int k);
    int n;
    wvalid = 1'b1;
    wdata  = beatData[k];
    wstrb  = beatStrb[k];
    wid    = beatWid[k];
    wlast  = beatLast[k];
    n = 0;
    while (wready !== 1'b1 && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    if (wready !== 1'b1) checkOutput("w_timeout", 32'(wready), 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  // Called right after the terminating beat: B must already be up, then held, then retired.
  task automatic finishB(input int holdB, input logic [3:0] expId, input logic [1:0] expResp);
    checkOutput("b_lat", 32'(bvalid), 32'd1);
    checkOutput("wready_off", 32'(wready), 32'd0);
    for (int i = 0; i < holdB; i++) begin
      @(posedge clk); #1;
      checkOutput("b_hold", 32'(bvalid), 32'd1);
      checkOutput("aw_block", 32'(awready), 32'd0);
    end
    checkOutput("bid", 32'(bid), 32'(expId));
    checkOutput("bresp", 32'(bresp), 32'(expResp));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    checkOutput("b_done", 32'(bvalid), 32'd0);
    checkOutput("aw_back", 32'(awready), 32'd1);
  endtask

  task automatic readBack();
    while (touched.size() > 0) begin
      dbgAddr = ADDR_W'(touched.pop_front());
      @(posedge clk); #1;
      checkOutput("ram", dbgRdata, modelMem[dbgAddr]);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len8,
                               input logic [2:0] size, input logic [1:0] burst,
                               input int holdB, input bit doRead);
    logic [1:0] er;
    int         nb;
    modelBurst(id, addr, len8, size, burst, er, nb);
    sendAw(id, addr, len8, size, burst);
    for (int k = 0; k < nb; k++) sendBeat(k);
    finishB(holdB, id, er);
    if (doRead) readBack();
    else touched.delete();
  endtask

  // Linear directed sequence followed by randomized bursts.
  initial begin
    logic [3:0]  rId;
    logic [31:0] rAddr;
    logic [7:0]  rLen;
    logic [2:0]  rSize;
    logic [1:0]  rBurst;
    logic [1:0]  er;
    logic [31:0] oldWord;
    int          nb, sel, len4, lastAt;

    resetn  = 1'b0;
    awid    = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01;
    awlock  = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wid     = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready  = 1'b0;
    dbgAddr = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_awready", 32'(awready), 32'd0);
    checkOutput("rst_wready", 32'(wready), 32'd0);
    checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
    checkOutput("rst_bid", 32'(bid), 32'd0);
    checkOutput("rst_bresp", 32'(bresp), 32'd0);
    checkOutput("rst_dbg", dbgRdata, 32'd0);
    resetn = 1'b1;
    checkOutput("rel_awready0", 32'(awready), 32'd0);
    @(posedge clk); #1;
    checkOutput("rel_awready1", 32'(awready), 32'd1);

    $display("[TB] filling RAM");
    for (int i = 0; i < DEPTH / 16; i++) begin
      setBeats(4'(i), 15);
      applyStimulus(4'(i), BASE + 32'(64 * i), 8'd15, 3'b010, 2'b01, 0, 1'b0);
    end

    $display("[TB] directed INCR burst with B backpressure");
    setBeats(4'd3, 7);
    for (int k = 0; k < 8; k++) beatData[k] = 32'(k + 1) * 32'h1111_1111;
    applyStimulus(4'd3, 32'h40, 8'd7, 3'b010, 2'b01, 5, 1'b1);
    for (int k = 0; k < 8; k++) begin
      dbgAddr = ADDR_W'(16 + k);
      @(posedge clk); #1;
      checkOutput("incr_const", dbgRdata, 32'(k + 1) * 32'h1111_1111);
    end

    $display("[TB] directed WRAP burst");
    setBeats(4'd6, 3);
    applyStimulus(4'd6, 32'h0C, 8'd3, 3'b010, 2'b10, 0, 1'b1);
    dbgAddr = ADDR_W'(3);
    @(posedge clk); #1;
    checkOutput("wrap_first", dbgRdata, beatData[0]);
    dbgAddr = ADDR_W'(0);
    @(posedge clk); #1;
    checkOutput("wrap_second", dbgRdata, beatData[1]);

    $display("[TB] directed byte strobes");
    setBeats(4'd1, 0);
    beatData[0] = 32'h1234_5678;
    applyStimulus(4'd1, 32'hA0, 8'd0, 3'b010, 2'b00, 0, 1'b0);
    setBeats(4'd1, 0);
    beatData[0] = 32'hAABB_CCDD;
    beatStrb[0] = 4'b0101;
    applyStimulus(4'd1, 32'hA0, 8'd0, 3'b010, 2'b00, 0, 1'b1);
    dbgAddr = ADDR_W'(40);
    @(posedge clk); #1;
    checkOutput("strb_const", dbgRdata, 32'h12BB_56DD);

    $display("[TB] directed error responses");
    setBeats(4'd7, 3);
    applyStimulus(4'd7, 32'h200, 8'd3, 3'b011, 2'b01, 0, 1'b1);
    setBeats(4'd8, 1);
    touched.push_back(0);
    applyStimulus(4'd8, BASE + 32'(WIN_BYTES), 8'd1, 3'b010, 2'b01, 0, 1'b0);
    touched.push_back(0);
    readBack();
    setBeats(4'd9, 2);
    applyStimulus(4'd9, 32'h300, 8'd7, 3'b010, 2'b01, 1, 1'b1);

    $display("[TB] debug read during write");
    setBeats(4'd2, 0);
    oldWord     = modelMem[30];
    beatData[0] = ~oldWord;
    dbgAddr     = ADDR_W'(30);
    modelBurst(4'd2, 32'h78, 8'd0, 3'b010, 2'b00, er, nb);
    touched.delete();
    sendAw(4'd2, 32'h78, 8'd0, 3'b010, 2'b00);
    sendBeat(0);
    checkOutput("dbg_old", dbgRdata, oldWord);
    finishB(0, 4'd2, er);
    checkOutput("dbg_new", dbgRdata, ~oldWord);

    $display("[TB] reset in the middle of a burst");
    setBeats(4'd5, 16);
    sendAw(4'd5, 32'h100, 8'd7, 3'b010, 2'b01);
    sendBeat(0);
    sendBeat(1);
    modelMem[64] = beatData[0];
    modelMem[65] = beatData[1];
    resetn = 1'b0;
    #1;
    checkOutput("mid_awready", 32'(awready), 32'd0);
    checkOutput("mid_wready", 32'(wready), 32'd0);
    checkOutput("mid_bvalid", 32'(bvalid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_awready_up", 32'(awready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("mid_no_b", 32'(bvalid), 32'd0);
      @(posedge clk); #1;
    end
    touched.push_back(64);
    touched.push_back(65);
    touched.push_back(66);
    readBack();

    $display("[TB] randomized bursts");
    for (int t = 0; t < 40; t++) begin
      rId    = 4'($urandom);
      rBurst = 2'($urandom_range(0, 2));
      rLen   = 8'($urandom_range(0, 15));
      if (rBurst == 2'b10 && $urandom_range(0, 9) != 0) rLen = 8'((1 << $urandom_range(1, 4)) - 1);
      if ($urandom_range(0, 9) == 0) rLen[7:4] = 4'($urandom_range(1, 15));
      rSize  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      sel    = $urandom_range(0, 9);
      if (sel < 8)       rAddr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (sel == 8) rAddr = BASE + 32'(WIN_BYTES) - 32'(4 * $urandom_range(1, 8));
      else               rAddr = BASE + 32'(WIN_BYTES) + 32'(4 * $urandom_range(0, 4000));
      len4 = int'(rLen[3:0]);
      sel  = $urandom_range(0, 9);
      if (sel == 0)      lastAt = (len4 == 0) ? 0 : $urandom_range(0, len4 - 1);
      else if (sel == 1) lastAt = 16;
      else               lastAt = len4;
      setBeats(rId, lastAt);
      for (int k = 0; k < 16; k++) beatStrb[k] = 4'($urandom);
      if ($urandom_range(0, 9) == 0) beatWid[$urandom_range(0, len4)] = rId ^ 4'h8;
      applyStimulus(rId, rAddr, rLen, rSize, rBurst, $urandom_range(0, 2), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
